ball_tx_sequencer: RTL and testbench
====================================

BALL_TX_SEQUENCER -- requirements
Module: ball_tx_sequencer

Interface
REQ-001 Parameter SLV_ADDR, default 7'h17, 7-bit I2C address of the peer ball-receiver slave.
REQ-002 Parameter MAX_RETRY, default 3, NACK retries allowed per transfer after the first attempt.
REQ-003 Parameter GAP_CYCLES, default 1000, idle clk cycles between a NACK STOP and the retry START.
REQ-004 clk  in  1  single system clock; all logic rising-edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 trigger  in  1  one-cycle pulse requesting transmission of the ball state.
REQ-007 y0, y1, yspeed, gravity, ballspeed  in  8 each  ball state, sampled on acceptance.
REQ-008 cmd_valid  out  1  command request to the byte-level I2C master engine.
REQ-009 cmd  out  2  engine command: 00 START, 01 WRITE, 10 STOP.
REQ-010 tx_data  out  8  byte for a WRITE command.
REQ-011 cmd_ready  in  1  engine accepts the command when cmd_valid and cmd_ready are both high.
REQ-012 cmd_done  in  1  one-cycle pulse when the accepted command completes on the bus.
REQ-013 ack_err  in  1  qualified by cmd_done on a WRITE; 1 means the slave NACKed.
REQ-014 busy  out  1  high from trigger acceptance until tx_done or tx_err; drives the peer's responsing_i2c.
REQ-015 tx_done  out  1  one-cycle pulse on successful transfer.
REQ-016 tx_err  out  1  one-cycle pulse when retries are exhausted.

Function
REQ-017 States SHALL be IDLE, ISSUE, WAIT_DONE, GAP and FINISH.
REQ-018 Transfer sequence, 9 commands: START; WRITE {SLV_ADDR,0}; WRITE 8'h00 register pointer; WRITE y0, y1, yspeed, gravity, ballspeed; STOP.
REQ-019 trigger high in IDLE SHALL latch all five inputs into a snapshot and go to ISSUE on the next edge; busy rises in that same cycle.
REQ-020 ISSUE SHALL assert cmd_valid with stable cmd and tx_data until the handshake; after the handshake cmd_valid drops and the state goes to WAIT_DONE.
REQ-021 WAIT_DONE SHALL ignore cmd_ready; on cmd_done with no error it advances a 4-bit step index (0..8) and returns to ISSUE, or goes to FINISH after step 8.
REQ-022 On cmd_done with ack_err=1 for any WRITE, remaining bytes SHALL be skipped, step set to STOP, then GAP entered after the STOP completes.
REQ-023 GAP SHALL count GAP_CYCLES clocks, then restart at step 0 (START) with the same snapshot, if the retry count is below MAX_RETRY.
REQ-024 After MAX_RETRY+1 failed attempts, the post-STOP path SHALL go to FINISH with tx_err instead of GAP.
REQ-025 FINISH SHALL pulse exactly one of tx_done or tx_err for one cycle, drop busy in the same cycle, and return to IDLE.
REQ-026 ack_err on START or STOP completion SHALL be ignored.
REQ-027 A trigger while not IDLE SHALL set a single pending flag; further triggers are lost.
REQ-028 From IDLE with pending set, a new transfer SHALL start with a fresh snapshot taken in that IDLE cycle, and the pending flag SHALL clear.
REQ-029 The snapshot SHALL NOT change during a transfer, including across retries.
REQ-030 The retry counter SHALL be wide enough for MAX_RETRY and SHALL clear at each new transfer.

Reset
REQ-031 On reset low: state IDLE; cmd_valid, busy, tx_done, tx_err and pending SHALL be 0; cmd 00; tx_data 00; counters and snapshot 0.
REQ-032 Reset during a transfer SHALL abandon it immediately with no STOP issued; bus recovery belongs to the engine.
REQ-033 Release of reset SHALL take effect on the first clk edge with reset high.

Verification
REQ-034 y0..ballspeed = 10,20,3,1,5, engine always ready, done 4 cycles after accept -> commands 00,01/2E,01/00,01/0A,01/14,01/03,01/01,01/05,10; one tx_done; busy high throughout.
REQ-035 cmd_ready held low 7 cycles -> cmd_valid, cmd and tx_data stable for all 7 cycles; no command skipped.
REQ-036 NACK on the address byte every attempt, MAX_RETRY=3 -> 4 START/addr/STOP groups, each separated by >= GAP_CYCLES; one tx_err; no tx_done.
REQ-037 NACK on the gravity byte in the first attempt only -> STOP, gap, full resend of the identical snapshot; tx_done.
REQ-038 Two triggers during a transfer, with inputs changed between them -> exactly one follow-up transfer carrying the values present in its IDLE cycle.
REQ-039 Reset low during the data bytes -> all outputs at reset values on the next edge; a fresh trigger after release completes normally.

Source files
------------

// File: rtl/ball_tx_sequencer.sv
// ball_tx_sequencer: sends one ball-state frame to a peer I2C slave through a
// byte-level I2C master engine. Each transfer is nine commands: START, address
// write, register pointer 0x00, five snapshot bytes, then STOP. A NACKed write
// aborts to STOP, and after an idle gap the whole frame is retried with the
// same snapshot.
//
// Ports
//   clk, reset         rising-edge clock, asynchronous active-low reset
//   trigger            request pulse; latches y0..ballspeed when accepted
//   y0..ballspeed      ball state bytes
//   cmd_valid/cmd      engine command request (00 START, 01 WRITE, 10 STOP)
//   tx_data            byte for a WRITE
//   cmd_ready          engine accepts when cmd_valid and cmd_ready are both high
//   cmd_done/ack_err   completion pulse; ack_err flags a NACK on a WRITE
//   busy               high from acceptance until the tx_done/tx_err cycle
//   tx_done/tx_err     one-cycle result pulses
module ball_tx_sequencer #(
    parameter logic [6:0]  SLV_ADDR   = 7'h17,
    parameter int unsigned MAX_RETRY  = 3,
    parameter int unsigned GAP_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       trigger,
    input  logic [7:0] y0,
    input  logic [7:0] y1,
    input  logic [7:0] yspeed,
    input  logic [7:0] gravity,
    input  logic [7:0] ballspeed,
    output logic       cmd_valid,
    output logic [1:0] cmd,
    output logic [7:0] tx_data,
    input  logic       cmd_ready,
    input  logic       cmd_done,
    input  logic       ack_err,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int unsigned RETRY_W  = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam int unsigned GAP_W    = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
    localparam int unsigned GAP_LAST = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] ISSUE     = 3'd1;
    localparam logic [2:0] WAIT_DONE = 3'd2;
    localparam logic [2:0] GAP       = 3'd3;
    localparam logic [2:0] FINISH    = 3'd4;

    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_STOP  = 2'b10;

    localparam logic [3:0] STEP_START = 4'd0;
    localparam logic [3:0] STEP_STOP  = 4'd8;

    logic [2:0]         state, state_nxt;
    logic [3:0]         step, step_nxt;
    logic [RETRY_W-1:0] retry_cnt, retry_nxt;
    logic [GAP_W-1:0]   gap_cnt, gap_nxt;
    logic               nack_seen, nack_nxt;
    logic               pending, pending_nxt;
    logic [4:0][7:0]    snap, snap_nxt;
    logic               cmd_valid_nxt;
    logic [1:0]         cmd_nxt;
    logic [7:0]         tx_data_nxt;
    logic               busy_nxt, tx_done_nxt, tx_err_nxt;

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            step      <= STEP_START;
            retry_cnt <= '0;
            gap_cnt   <= '0;
            nack_seen <= 1'b0;
            pending   <= 1'b0;
            snap      <= '0;
            cmd_valid <= 1'b0;
            cmd       <= CMD_START;
            tx_data   <= 8'h00;
            busy      <= 1'b0;
            tx_done   <= 1'b0;
            tx_err    <= 1'b0;
        end else begin
            state     <= state_nxt;
            step      <= step_nxt;
            retry_cnt <= retry_nxt;
            gap_cnt   <= gap_nxt;
            nack_seen <= nack_nxt;
            pending   <= pending_nxt;
            snap      <= snap_nxt;
            cmd_valid <= cmd_valid_nxt;
            cmd       <= cmd_nxt;
            tx_data   <= tx_data_nxt;
            busy      <= busy_nxt;
            tx_done   <= tx_done_nxt;
            tx_err    <= tx_err_nxt;
        end
    end

    // Next-state, sequencing and output decode
    always_comb begin
        state_nxt     = state;
        step_nxt      = step;
        retry_nxt     = retry_cnt;
        gap_nxt       = gap_cnt;
        nack_nxt      = nack_seen;
        pending_nxt   = pending;
        snap_nxt      = snap;
        busy_nxt      = busy;
        tx_done_nxt   = 1'b0;
        tx_err_nxt    = 1'b0;
        cmd_valid_nxt = 1'b0;
        cmd_nxt       = cmd;
        tx_data_nxt   = tx_data;

        // Only one request can wait behind an active transfer
        if (trigger && (state != IDLE)) begin
            pending_nxt = 1'b1;
        end

        case (state)
            IDLE: begin
                if (trigger || pending) begin
                    snap_nxt    = {ballspeed, gravity, yspeed, y1, y0};
                    pending_nxt = 1'b0;
                    step_nxt    = STEP_START;
                    retry_nxt   = '0;
                    nack_nxt    = 1'b0;
                    busy_nxt    = 1'b1;
                    state_nxt   = ISSUE;
                end
            end
            ISSUE: begin
                if (cmd_valid && cmd_ready) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (cmd_done) begin
                    if (step == STEP_STOP) begin
                        if (!nack_seen) begin
                            tx_done_nxt = 1'b1;
                            busy_nxt    = 1'b0;
                            state_nxt   = FINISH;
                        end else if (retry_cnt < RETRY_W'(MAX_RETRY)) begin
                            retry_nxt = retry_cnt + RETRY_W'(1);
                            gap_nxt   = '0;
                            state_nxt = GAP;
                        end else begin
                            tx_err_nxt = 1'b1;
                            busy_nxt   = 1'b0;
                            state_nxt  = FINISH;
                        end
                    end else if (ack_err && (step != STEP_START)) begin
                        // NACK on a write: skip straight to STOP
                        step_nxt  = STEP_STOP;
                        nack_nxt  = 1'b1;
                        state_nxt = ISSUE;
                    end else begin
                        step_nxt  = step + 4'd1;
                        state_nxt = ISSUE;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GAP_W'(GAP_LAST)) begin
                    step_nxt  = STEP_START;
                    nack_nxt  = 1'b0;
                    state_nxt = ISSUE;
                end else begin
                    gap_nxt = gap_cnt + GAP_W'(1);
                end
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Command presented for whichever step the next ISSUE cycle serves
        cmd_valid_nxt = (state_nxt == ISSUE);
        if (cmd_valid_nxt) begin
            case (step_nxt)
                4'd0: begin cmd_nxt = CMD_START; tx_data_nxt = 8'h00;             end
                4'd1: begin cmd_nxt = CMD_WRITE; tx_data_nxt = {SLV_ADDR, 1'b0}; end
                4'd2: begin cmd_nxt = CMD_WRITE; tx_data_nxt = 8'h00;             end
                4'd3: begin cmd_nxt = CMD_WRITE; tx_data_nxt = snap_nxt[0];       end
                4'd4: begin cmd_nxt = CMD_WRITE; tx_data_nxt = snap_nxt[1];       end
                4'd5: begin cmd_nxt = CMD_WRITE; tx_data_nxt = snap_nxt[2];       end
                4'd6: begin cmd_nxt = CMD_WRITE; tx_data_nxt = snap_nxt[3];       end
                4'd7: begin cmd_nxt = CMD_WRITE; tx_data_nxt = snap_nxt[4];       end
                default: begin cmd_nxt = CMD_STOP; tx_data_nxt = 8'h00;          end
            endcase
        end
    end

endmodule

// File: tb/tb_ball_tx_sequencer.sv
// Bench for ball_tx_sequencer: behavioural I2C engine with programmable stall
// and NACK policy, a frame-level reference model, vector table plus directed
// pending/reset sequences and randomized transfers.
module tb_ball_tx_sequencer;

    localparam int unsigned GAP  = 20;
    localparam int unsigned MAXR = 3;
    localparam logic [6:0]  ADDR = 7'h17;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       trigger = 1'b0;
    logic [7:0] y0 = '0, y1 = '0, yspeed = '0, gravity = '0, ballspeed = '0;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic [7:0] tx_data;
    logic       cmd_ready = 1'b0;
    logic       cmd_done = 1'b0;
    logic       ack_err = 1'b0;
    logic       busy, tx_done, tx_err;

    ball_tx_sequencer #(
        .SLV_ADDR  (ADDR),
        .MAX_RETRY (MAXR),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .trigger  (trigger),
        .y0       (y0),
        .y1       (y1),
        .yspeed   (yspeed),
        .gravity  (gravity),
        .ballspeed(ballspeed),
        .cmd_valid(cmd_valid),
        .cmd      (cmd),
        .tx_data  (tx_data),
        .cmd_ready(cmd_ready),
        .cmd_done (cmd_done),
        .ack_err  (ack_err),
        .busy     (busy),
        .tx_done  (tx_done),
        .tx_err   (tx_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [9:0] log_q[$];
    int         cyc_q[$];
    logic [9:0] exp_q[$];

    int         nack_pos[8];
    logic       ctrl_err = 1'b0;
    int         ready_delay = 0;
    logic       rand_ready = 1'b0;
    logic       scramble = 1'b0;

    int         eng_attempt = -1;
    int         eng_idx = 0;
    int         eng_lat = 0;
    int         wait_n = 0;
    int         cur_wait = 0;
    logic       cur_nack = 1'b0;
    logic [1:0] hold_cmd = '0;
    logic [7:0] hold_data = '0;
    logic       prev_pulse = 1'b0;

    typedef struct {
        logic [4:0][7:0] s;
        int rdly;
        int mode;
        int edone;
        int eerr;
    } vec_t;
    vec_t vt[7];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [4:0][7:0] mk(input int a, input int b, input int c, input int d, input int e);
        return {8'(e), 8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    // Engine: stalls ready, logs accepted commands, answers done 4 cycles later
    initial forever begin
        @(negedge clk);
        cmd_done = 1'b0;
        ack_err  = 1'($urandom_range(0, 1));
        if (!reset) begin
            cmd_ready = 1'b0;
            eng_lat   = 0;
            wait_n    = 0;
        end else if (eng_lat > 0) begin
            cmd_ready = 1'b0;
            eng_lat--;
            if (eng_lat == 0) begin
                cmd_done = 1'b1;
                ack_err  = cur_nack;
            end
        end else if (cmd_valid) begin
            if (wait_n == 0) begin
                hold_cmd  = cmd;
                hold_data = tx_data;
                cur_wait  = rand_ready ? int'($urandom_range(0, 3)) : ready_delay;
            end else begin
                check("stall_cmd_stable", int'(cmd), int'(hold_cmd));
                check("stall_data_stable", int'(tx_data), int'(hold_data));
            end
            if (wait_n >= cur_wait) begin
                cmd_ready = 1'b1;
                log_q.push_back({cmd, (cmd == 2'b01) ? tx_data : 8'h00});
                cyc_q.push_back(cyc);
                if (cmd == 2'b00) begin
                    eng_attempt++;
                    eng_idx = 0;
                end else begin
                    eng_idx++;
                end
                if (cmd == 2'b01)
                    cur_nack = (eng_attempt >= 0) && (eng_attempt < 8) && (nack_pos[eng_attempt & 7] == eng_idx);
                else
                    cur_nack = ctrl_err;
                eng_lat = 4;
                wait_n  = 0;
            end else begin
                cmd_ready = 1'b0;
                wait_n++;
            end
        end else begin
            cmd_ready = 1'b0;
        end
    end

    // Result pulse properties
    initial forever begin
        @(negedge clk);
        if (reset && (tx_done || tx_err)) begin
            check("pulse_busy_low", int'(busy), 0);
            check("pulse_exclusive", int'(tx_done & tx_err), 0);
            check("pulse_one_cycle", int'(prev_pulse), 0);
        end
        prev_pulse = tx_done | tx_err;
    end

    task automatic set_policy(input int mode);
        for (int a = 0; a < 8; a++) nack_pos[a] = 0;
        ctrl_err = 1'b0;
        case (mode)
            1: for (int a = 0; a < 8; a++) nack_pos[a] = 1;
            2: nack_pos[0] = 6;
            3: begin nack_pos[0] = 3; nack_pos[1] = 3; end
            4: ctrl_err = 1'b1;
            5: for (int a = 0; a < 8; a++)
                   nack_pos[a] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 0;
            default: ;
        endcase
    endtask

    // Frame-level model: appends expected commands, returns 1 on success
    function automatic int build_expected(input logic [4:0][7:0] s);
        logic [7:0] b[8];
        int ok;
        int nk;
        ok = 0;
        b[0] = 8'h00;
        b[1] = {ADDR, 1'b0};
        b[2] = 8'h00;
        for (int i = 0; i < 5; i++) b[3 + i] = s[i];
        for (int a = 0; a <= int'(MAXR) && ok == 0; a++) begin
            nk = 0;
            exp_q.push_back({2'b00, 8'h00});
            for (int i = 1; i <= 7; i++) begin
                exp_q.push_back({2'b01, b[i]});
                if (nack_pos[a] == i) begin
                    nk = 1;
                    break;
                end
            end
            exp_q.push_back({2'b10, 8'h00});
            if (nk == 0) ok = 1;
        end
        return ok;
    endfunction

    task automatic set_inputs(input logic [4:0][7:0] s);
        y0 = s[0]; y1 = s[1]; yspeed = s[2]; gravity = s[3]; ballspeed = s[4];
    endtask

    task automatic pulse_trigger();
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
    endtask

    task automatic clear_logs();
        log_q.delete();
        cyc_q.delete();
        exp_q.delete();
        eng_attempt = -1;
        eng_idx = 0;
    endtask

    task automatic wait_end(input string tag, input int budget, input bit chk_busy, output int gd, output int ge);
        int n;
        int bad;
        bit seen;
        n = 0; bad = 0; seen = 0; gd = 0; ge = 0;
        while (!seen && n < budget) begin
            @(negedge clk);
            n++;
            if (tx_done || tx_err) begin
                seen = 1;
                gd = int'(tx_done);
                ge = int'(tx_err);
            end else begin
                if (chk_busy && !busy) bad++;
                if (scramble) begin
                    y0 = 8'($urandom); y1 = 8'($urandom); yspeed = 8'($urandom);
                    gravity = 8'($urandom); ballspeed = 8'($urandom);
                end
            end
        end
        check($sformatf("%s end_seen", tag), int'(seen), 1);
        if (chk_busy) check($sformatf("%s busy_held", tag), bad, 0);
    endtask

    task automatic compare_logs(input string tag, input bit chk_gap);
        int last_stop;
        check($sformatf("%s cmd_count", tag), log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            check($sformatf("%s cmd%0d", tag, i), int'(log_q[i]), int'(exp_q[i]));
        if (chk_gap) begin
            last_stop = -1;
            for (int i = 0; i < log_q.size(); i++) begin
                if (log_q[i][9:8] == 2'b10) last_stop = cyc_q[i];
                else if (log_q[i][9:8] == 2'b00 && last_stop >= 0)
                    check($sformatf("%s gap_before_cmd%0d", tag, i),
                          int'((cyc_q[i] - last_stop) >= int'(GAP)), 1);
            end
        end
    endtask

    task automatic idle_check(input string tag, input int n);
        int bad;
        bad = 0;
        repeat (n) begin
            @(negedge clk);
            if (busy || cmd_valid || tx_done || tx_err) bad++;
        end
        check(tag, bad, 0);
    endtask

    task automatic run_vec(input string tag, input logic [4:0][7:0] s, input int rdly, input int mode,
                           input int edone, input int eerr);
        int ok, gd, ge, xd, xe;
        set_policy(mode);
        ready_delay = (rdly < 0) ? 0 : rdly;
        rand_ready  = (rdly < 0);
        clear_logs();
        ok = build_expected(s);
        xd = (edone < 0) ? ok : edone;
        xe = (eerr < 0) ? (1 - ok) : eerr;
        set_inputs(s);
        scramble = 1'b1;
        pulse_trigger();
        wait_end(tag, 5000, 1, gd, ge);
        scramble = 1'b0;
        check($sformatf("%s tx_done", tag), gd, xd);
        check($sformatf("%s tx_err", tag), ge, xe);
        compare_logs(tag, 1);
        idle_check($sformatf("%s idle_after", tag), 8);
    endtask

    initial begin
        int gold[9];
        int gd, ge, starts, n0;
        logic [4:0][7:0] sa, sd, rs;

        gold = '{'h000, 'h12E, 'h100, 'h10A, 'h114, 'h103, 'h101, 'h105, 'h200};
        vt[0] = '{mk(10, 20, 3, 1, 5),      0, 0, 1, 0};
        vt[1] = '{mk(7, 8, 9, 10, 11),      7, 0, 1, 0};
        vt[2] = '{mk(1, 2, 3, 4, 5),        0, 1, 0, 1};
        vt[3] = '{mk(33, 44, 55, 66, 77),   0, 2, 1, 0};
        vt[4] = '{mk(90, 91, 92, 93, 94),   2, 3, 1, 0};
        vt[5] = '{mk(0, 0, 0, 0, 0),        1, 4, 1, 0};
        vt[6] = '{mk(255, 255, 255, 255, 255), 0, 0, 1, 0};

        // Reset values while reset is held
        #1;
        check("rst cmd_valid", int'(cmd_valid), 0);
        check("rst cmd", int'(cmd), 0);
        check("rst tx_data", int'(tx_data), 0);
        check("rst busy", int'(busy), 0);
        check("rst tx_done", int'(tx_done), 0);
        check("rst tx_err", int'(tx_err), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        idle_check("idle_no_trigger", 6);

        for (int i = 0; i < 7; i++) begin
            run_vec($sformatf("vec%0d", i), vt[i].s, vt[i].rdly, vt[i].mode, vt[i].edone, vt[i].eerr);
            if (i == 0) begin
                for (int k = 0; k < 9 && k < log_q.size(); k++)
                    check($sformatf("vec0 gold%0d", k), int'(log_q[k]), gold[k]);
            end
            if (vt[i].mode == 1) begin
                starts = 0;
                foreach (log_q[k]) if (log_q[k][9:8] == 2'b00) starts++;
                check("nack_addr start_groups", starts, int'(MAXR) + 1);
            end
        end

        // Two triggers during a transfer: one follow-up with IDLE-cycle values
        set_policy(0);
        ready_delay = 0;
        rand_ready = 1'b0;
        clear_logs();
        sa = mk(11, 22, 33, 44, 55);
        sd = mk(201, 202, 203, 204, 205);
        set_inputs(sa);
        pulse_trigger();
        repeat (5) @(negedge clk);
        set_inputs(mk(101, 102, 103, 104, 105));
        pulse_trigger();
        repeat (5) @(negedge clk);
        set_inputs(mk(151, 152, 153, 154, 155));
        pulse_trigger();
        set_inputs(sd);
        void'(build_expected(sa));
        void'(build_expected(sd));
        wait_end("pend first", 2000, 1, gd, ge);
        check("pend first tx_done", gd, 1);
        wait_end("pend second", 2000, 0, gd, ge);
        check("pend second tx_done", gd, 1);
        compare_logs("pend", 0);
        idle_check("pend no_third", 60);

        // Reset in the middle of the data bytes, then a clean transfer
        clear_logs();
        set_inputs(mk(60, 61, 62, 63, 64));
        pulse_trigger();
        n0 = 0;
        while (log_q.size() < 5 && n0 < 300) begin
            @(negedge clk);
            n0++;
        end
        check("rstmid reached_data", int'(log_q.size() >= 5), 1);
        #2 reset = 1'b0;
        #1;
        check("rstmid cmd_valid", int'(cmd_valid), 0);
        check("rstmid cmd", int'(cmd), 0);
        check("rstmid tx_data", int'(tx_data), 0);
        check("rstmid busy", int'(busy), 0);
        check("rstmid tx_done", int'(tx_done), 0);
        check("rstmid tx_err", int'(tx_err), 0);
        n0 = log_q.size();
        repeat (3) @(negedge clk);
        check("rstmid no_cmds", log_q.size(), n0);
        reset = 1'b1;
        idle_check("rstmid idle_after_release", 6);
        run_vec("after_rst", mk(70, 71, 72, 73, 74), 0, 0, 1, 0);

        // Randomized transfers with random stalls and NACKs
        for (int r = 0; r < 8; r++) begin
            rs = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
            run_vec($sformatf("rand%0d", r), rs, -1, 5, -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
